// File: rtl/instr_queue_if.sv
// Fetch-side bundle between instruction memory, instr_queue and controller.
// master drives enqueue/dequeue/flush; slave is the queue itself.
interface instr_queue_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int OP_W  = 4
);
    logic [WIDTH-1:0]       data;
    logic                   load;
    logic                   next;
    logic                   flush;
    logic [WIDTH-1:0]       out;
    logic [OP_W-1:0]        opcode;
    logic                   valid;
    logic                   ready;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    modport master (
        output data, load, next, flush,
        input  out, opcode, valid, ready, count, overflow
    );

    modport slave (
        input  data, load, next, flush,
        output out, opcode, valid, ready, count, overflow
    );
endinterface

// File: rtl/instr_queue.sv
// Circular instruction FIFO: lets fetch run ahead of the controller FSM.
// Define INSTR_QUEUE_BYPASS_EN for same-cycle pass-through on an empty queue.
module instr_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int OP_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    instr_queue_if.slave q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [PW-1:0] PINC = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW-1:0]    rd_nxt;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;
    logic             byp_thru;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL);
    assign rd_nxt = rd_ptr_q + PINC;

`ifdef INSTR_QUEUE_BYPASS_EN
    logic byp;
    assign byp      = empty && q.load && !q.flush;
    assign byp_thru = byp && q.next;
    assign q.out    = byp ? q.data : out_q;
    assign q.valid  = !empty || byp;
`else
    assign byp_thru = 1'b0;
    assign q.out    = out_q;
    assign q.valid  = !empty;
`endif

    assign q.opcode   = q.out[WIDTH-1 -: OP_W];
    assign q.ready    = !full;
    assign q.count    = count_q;
    assign q.overflow = overflow_q;

    // Accept/consume decisions; flush overrides both.
    always_comb begin
        deq = !q.flush && q.next && !empty;
        enq = !q.flush && q.load && (!full || deq) && !byp_thru;
    end

    // Pointer and occupancy next-state; never depends on data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PINC;
            if (deq) rd_ptr_d = rd_nxt;
            if (enq && !deq) count_d = count_q + ONE;
            if (deq && !enq) count_d = count_q - ONE;
        end
    end

    // Head register: next oldest word, or hold the last one when draining.
    always_comb begin
        out_d = out_q;
        if (byp_thru) begin
            out_d = q.data;
        end else if (enq && empty) begin
            out_d = q.data;
        end else if (deq && count_q != ONE) begin
            out_d = mem_q[rd_nxt];
        end else if (deq && enq) begin
            out_d = q.data;
        end
    end

    // Sticky flag for a load dropped against a full queue.
    always_comb begin
        overflow_d = overflow_q;
        if (q.load && full && !deq && !q.flush) overflow_d = 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; only the slot under the write pointer changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (enq) begin
            mem_q[wr_ptr_q] <= q.data;
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
// Randomised + directed bench for instr_queue against a queue-based model.
// Honours INSTR_QUEUE_BYPASS_EN when building the expected outputs.
module tb_instr_queue;
    localparam int W = 16;
    localparam int D = 4;
    localparam int O = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [W-1:0] mq[$];
    logic [W-1:0] last;
    logic         ovf;

    instr_queue_if #(.WIDTH(W), .DEPTH(D), .OP_W(O)) bus ();

    instr_queue #(.WIDTH(W), .DEPTH(D), .OP_W(O)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .q    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        last = '0;
        ovf  = 1'b0;
    endtask

    // Expected outputs for the current (pre-edge) cycle.
    task automatic check_all();
        logic [W-1:0] e_out;
        logic         e_val;
        int           n;
        n     = mq.size();
        e_val = (n != 0);
        e_out = e_val ? mq[0] : last;
`ifdef INSTR_QUEUE_BYPASS_EN
        if (n == 0 && bus.load && !bus.flush) begin
            e_out = bus.data;
            e_val = 1'b1;
        end
`endif
        chk("out", 32'(bus.out), 32'(e_out));
        chk("opcode", 32'(bus.opcode), 32'(e_out[W-1 -: O]));
        chk("valid", 32'(bus.valid), 32'(e_val));
        chk("ready", 32'(bus.ready), 32'(n != D));
        chk("count", 32'(bus.count), 32'(n));
        chk("overflow", 32'(bus.overflow), 32'(ovf));
    endtask

    // Apply the clock-edge rules to the model.
    task automatic model_edge(input logic ld, input logic [W-1:0] d,
                              input logic nx, input logic fl);
        bit do_deq;
        bit do_enq;
        if (fl) begin
            if (mq.size() != 0) last = mq[0];
            mq.delete();
            return;
        end
`ifdef INSTR_QUEUE_BYPASS_EN
        if (mq.size() == 0 && ld && nx) begin
            last = d;
            return;
        end
`endif
        do_deq = nx && (mq.size() != 0);
        do_enq = ld && ((mq.size() < D) || do_deq);
        if (ld && !do_enq) ovf = 1'b1;
        if (do_deq) last = mq.pop_front();
        if (do_enq) mq.push_back(d);
    endtask

    task automatic step(input logic ld, input logic [W-1:0] d,
                        input logic nx, input logic fl);
        bus.load  = ld;
        bus.data  = d;
        bus.next  = nx;
        bus.flush = fl;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge(ld, d, nx, fl);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.load  = 1'b0;
        bus.data  = '0;
        bus.next  = 1'b0;
        bus.flush = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-stream, observed without a clock edge.
        step(1'b1, 16'h1111, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0);
        bus.load = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill, overflow, full load+next, drain.
        step(1'b1, 16'h1A00, 1'b0, 1'b0);
        step(1'b1, 16'h2B00, 1'b0, 1'b0);
        step(1'b1, 16'h3C00, 1'b0, 1'b0);
        step(1'b1, 16'h4D00, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h5E00, 1'b0, 1'b0);
        step(1'b1, 16'h6F00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Flush with a competing load, then reload.
        step(1'b1, 16'hA001, 1'b0, 1'b0);
        step(1'b1, 16'hA002, 1'b0, 1'b0);
        step(1'b1, 16'hA003, 1'b0, 1'b0);
        step(1'b1, 16'h7777, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h8888, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Ten load/next pairs across a pointer wrap.
        for (int i = 0; i < 10; i++)
            step(1'b1, 16'(16'hC000 + i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

        // Load into an empty queue (bypass shows it the same cycle).
        step(1'b1, 16'h9999, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h9ABC, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60,
                 16'($urandom),
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
